// File: rtl/result_bcd_serializer_pkg.sv
// Shared types, widths and double-dabble helpers for the result BCD serializer.
package result_bcd_serializer_pkg;
    localparam int RES_W      = 11;
    localparam int DIG_W      = 4;
    localparam int BCD_DIGITS = 4;
    localparam int CONV_ITERS = 11;
    localparam int BCD_W      = DIG_W * BCD_DIGITS;
    localparam int ITER_W     = $clog2(CONV_ITERS + 1);
    localparam int IDX_W      = $clog2(BCD_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND
    } state_e;

    // One double-dabble correction step: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[DIG_W*i +: DIG_W] >= DIG_W'(5)) r[DIG_W*i +: DIG_W] = b[DIG_W*i +: DIG_W] + DIG_W'(3);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] msd_index(input logic [BCD_W-1:0] b);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 1; i < BCD_DIGITS; i++) begin
            if (b[DIG_W*i +: DIG_W] != '0) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [DIG_W-1:0] nibble(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] idx);
        return b[DIG_W*int'(idx) +: DIG_W];
    endfunction
endpackage

// File: rtl/result_bcd_serializer_if.sv
// Result input pulse and digit output handshake of the BCD serializer.
interface result_bcd_serializer_if;
    import result_bcd_serializer_pkg::*;

    logic             res_valid;
    logic [RES_W-1:0] res;
    logic             dig_valid;
    logic [DIG_W-1:0] dig;
    logic             dig_last;
    logic             dig_ready;

    modport master (output res_valid, res, dig_ready, input dig_valid, dig, dig_last);
    modport slave  (input res_valid, res, dig_ready, output dig_valid, dig, dig_last);
endinterface

// File: rtl/result_bcd_serializer_result_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is taken when a pop happens on the same edge.
module result_fifo
    import result_bcd_serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [RES_W-1:0]       wdata,
    output logic [RES_W-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [RES_W-1:0] mem_q [DEPTH];
    logic [RES_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full    = count_q[AW];
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/result_bcd_serializer.sv
// Buffers 11-bit results, converts each to 4-digit BCD with a sequential
// double-dabble, and streams the digits MSD-first over valid/ready.
module result_bcd_serializer
    import result_bcd_serializer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter bit SUPPRESS_LZ = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    result_bcd_serializer_if.slave  bus,
    input  logic                    clr_ovf,
    output logic                    busy,
    output logic                    ovf,
    output logic [$clog2(DEPTH):0]  fifo_cnt
);
    state_e            state_q, state_d;
    logic [RES_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic              dig_valid_q, dig_valid_d;
    logic              dig_last_q, dig_last_d;
    logic              ovf_q, ovf_d;

    logic              fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [RES_W-1:0]  fifo_rdata;

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.res_valid),
        .pop   (fifo_pop),
        .wdata (bus.res),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign fifo_drop     = bus.res_valid && fifo_full && !fifo_pop;
    assign bus.dig_valid = dig_valid_q;
    assign bus.dig       = dig_q;
    assign bus.dig_last  = dig_last_q;
    assign ovf           = ovf_q;
    assign busy          = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        iter_d      = iter_q;
        idx_d       = idx_q;
        dig_d       = dig_q;
        dig_valid_d = dig_valid_q;
        dig_last_d  = dig_last_q;
        fifo_pop    = 1'b0;
        bcd_adj     = dd_adjust(bcd_q);
        case (state_q)
            IDLE: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                bin_d    = fifo_rdata;
                bcd_d    = '0;
                iter_d   = '0;
                state_d  = CONV;
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                iter_d         = iter_q + ITER_W'(1);
                // Last shift: present the first digit straight from the finished BCD.
                if (iter_q == ITER_W'(CONV_ITERS - 1)) begin
                    state_d     = SEND;
                    idx_d       = SUPPRESS_LZ ? msd_index(bcd_d) : IDX_W'(BCD_DIGITS - 1);
                    dig_d       = nibble(bcd_d, idx_d);
                    dig_valid_d = 1'b1;
                    dig_last_d  = (idx_d == '0);
                end
            end
            SEND: if (bus.dig_ready) begin
                if (idx_q == '0) begin
                    state_d     = IDLE;
                    dig_valid_d = 1'b0;
                    dig_last_d  = 1'b0;
                end else begin
                    idx_d      = idx_q - IDX_W'(1);
                    dig_d      = nibble(bcd_q, idx_d);
                    dig_last_d = (idx_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
        // A drop on the same edge as a clear keeps the flag set.
        ovf_d = fifo_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            idx_q       <= '0;
            dig_q       <= '0;
            dig_valid_q <= 1'b0;
            dig_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            iter_q      <= iter_d;
            idx_q       <= idx_d;
            dig_q       <= dig_d;
            dig_valid_q <= dig_valid_d;
            dig_last_q  <= dig_last_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule
